load_store_unit: RTL and testbench

- Initiator side of the processor's data memory port: takes load/store requests from the execute stage and drives the word-wide single-port synchronous data RAM.
- RAM signals: 5-bit word address, 32-bit write data, 1-bit write enable, read data valid one clock after the address.
- Adds byte/halfword access on top of the word-only RAM: lane extraction with sign/zero extension for loads, read-modify-write for partial stores.
- Flags misaligned requests; one request outstanding at a time.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/lsu_lane_logic.sv | 46 ++++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: access-size encodings, FSM state type, data width, and a helper
// that flags misaligned or illegal requests.
package lsu_pkg;

   localparam int unsigned LSU_DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      LD_ADDR,
      LD_DATA,
      RMW_ADDR,
      RMW_DATA,
      ST_WR,
      RESP
   } lsu_state_e;

   // Size 11 is illegal; halves need even addresses, words need 4-byte alignment.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit.
// Request side : req_valid/req_ready handshake, req_we, req_size, req_sign,
//                req_addr (byte address), req_wdata (right-aligned).
// Response side: resp_valid pulse, resp_err, resp_rdata.
// RAM side     : mem_addr (word address), mem_wd, mem_we, mem_re, mem_rd.
// Modport slave is the unit; modport master is the execute stage plus RAM.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_sign;
   logic [ADDR_W+1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [DATA_W-1:0] resp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rd;

   modport slave (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wd, mem_we, mem_re
   );

   modport master (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wd, mem_we, mem_re
   );
endinterface

// File: rtl/lsu_lane_logic.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   i_word    - word read back from RAM
//   i_offset  - byte offset within the word
//   i_size    - access size (byte/half/word)
//   i_sign    - sign-extend narrow loads when 1
//   i_wdata   - right-aligned store data
//   o_ld_data - extracted and extended load value
//   o_st_data - i_word with the store lanes replaced by i_wdata
module lsu_lane_logic
   import lsu_pkg::*;
(
   input  logic [LSU_DATA_W-1:0] i_word,
   input  logic [1:0]            i_offset,
   input  logic [1:0]            i_size,
   input  logic                  i_sign,
   input  logic [LSU_DATA_W-1:0] i_wdata,
   output logic [LSU_DATA_W-1:0] o_ld_data,
   output logic [LSU_DATA_W-1:0] o_st_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte    = i_word[{i_offset, 3'b000} +: 8];
      w_half    = i_offset[1] ? i_word[31:16] : i_word[15:0];
      o_ld_data = i_word;
      o_st_data = i_word;
      case (i_size)
         SZ_BYTE: begin
            o_ld_data = {{24{i_sign & w_byte[7]}}, w_byte};
            o_st_data[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
         end
         SZ_HALF: begin
            o_ld_data = {{16{i_sign & w_half[15]}}, w_half};
            o_st_data[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: begin
            o_ld_data = i_word;
            o_st_data = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data memory port.
// Accepts one load/store at a time from the execute stage, drives a word-wide
// synchronous RAM (read data one clock after mem_re) and adds byte/halfword
// access via lane extraction (loads) and read-modify-write (partial stores).
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - request/response handshake and RAM signals (slave modport)
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = LSU_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   load_store_unit_if.slave         bus
);

   lsu_state_e        r_state, w_state_next;
   logic [1:0]        r_size;
   logic              r_sign;
   logic [1:0]        r_offset;
   logic [DATA_W-1:0] r_wdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wd;
   logic              r_mem_we;
   logic              r_mem_re;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [DATA_W-1:0] r_resp_rdata;

   logic              w_accept;
   logic              w_misalign;
   logic [DATA_W-1:0] w_ld_data;
   logic [DATA_W-1:0] w_st_data;

   lsu_lane_logic u_lane (
      .i_word    (bus.mem_rd),
      .i_offset  (r_offset),
      .i_size    (r_size),
      .i_sign    (r_sign),
      .i_wdata   (r_wdata),
      .o_ld_data (w_ld_data),
      .o_st_data (w_st_data)
   );

   always_comb begin
      w_accept     = bus.req_valid && (r_state == IDLE);
      w_misalign   = lsu_misaligned(bus.req_size, bus.req_addr[1:0]);
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_misalign)                w_state_next = RESP;
               else if (!bus.req_we)          w_state_next = LD_ADDR;
               else if (bus.req_size == SZ_WORD) w_state_next = ST_WR;
               else                           w_state_next = RMW_ADDR;
            end
         end
         LD_ADDR:  w_state_next = LD_DATA;
         LD_DATA:  w_state_next = RESP;
         RMW_ADDR: w_state_next = RMW_DATA;
         RMW_DATA: w_state_next = ST_WR;
         ST_WR:    w_state_next = RESP;
         RESP:     w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_size       <= SZ_BYTE;
         r_sign       <= 1'b0;
         r_offset     <= 2'b00;
         r_wdata      <= '0;
         r_mem_addr   <= '0;
         r_mem_wd     <= '0;
         r_mem_we     <= 1'b0;
         r_mem_re     <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         // Strobes are registered from the next state so they line up with it.
         r_mem_re     <= (w_state_next == LD_ADDR) || (w_state_next == RMW_ADDR);
         r_mem_we     <= (w_state_next == ST_WR);
         r_resp_valid <= (w_state_next == RESP);
         // Only the error path goes straight from IDLE to RESP.
         r_resp_err   <= w_accept && w_misalign;
         if (w_accept) begin
            r_size       <= bus.req_size;
            r_sign       <= bus.req_sign;
            r_offset     <= bus.req_addr[1:0];
            r_wdata      <= bus.req_wdata;
            r_mem_addr   <= bus.req_addr[ADDR_W+1:2];
            r_mem_wd     <= bus.req_wdata;
            r_resp_rdata <= '0;
         end
         if (r_state == LD_DATA)  r_resp_rdata <= w_ld_data;
         if (r_state == RMW_DATA) r_mem_wd     <= w_st_data;
      end
   end

   assign bus.req_ready  = (r_state == IDLE);
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wd     = r_mem_wd;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_re     = r_mem_re;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural RAM.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   load_store_unit_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   load_store_unit #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM model plus a bench-side preload port (single writer).
   logic [31:0] mem [32];
   logic        pre_we;
   logic [4:0]  pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;
      if (bus.mem_re) bus.mem_rd <= mem[bus.mem_addr];
   end

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk);
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Drives one request from a negedge, observes 8 following negedges.
   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [6:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output int n_re, output int n_we, output int n_both,
                        output int n_resp, output logic [4:0] we_addr);
      lat = 0; err = 1'bx; rd = 'x; n_re = 0; n_we = 0; n_both = 0; n_resp = 0;
      we_addr = 'x;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_sign = sg;
      bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) bus.req_valid = 1'b0;
         if (bus.mem_re) n_re++;
         if (bus.mem_we) begin n_we++; we_addr = bus.mem_addr; end
         if (bus.mem_re && bus.mem_we) n_both++;
         if (bus.resp_valid) begin
            n_resp++;
            if (lat == 0) begin lat = k; err = bus.resp_err; rd = bus.resp_rdata; end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_sign = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      #1;
      total++;
      if ({bus.resp_valid, bus.resp_err, bus.mem_we, bus.mem_re} !== 4'b0000)
         $display("FAIL reset_strobes got=%b exp=0000",
                  {bus.resp_valid, bus.resp_err, bus.mem_we, bus.mem_re});
      else passed++;
      total++;
      if ({bus.resp_rdata, bus.mem_wd, bus.mem_addr} !== 69'd0)
         $display("FAIL reset_data got rdata=%h wd=%h addr=%h exp=0", bus.resp_rdata,
                  bus.mem_wd, bus.mem_addr);
      else passed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
      else passed++;
   endtask

   task automatic test_rmw_reset();
      int n_resp;
      int n_we;
      preload(5'd3, 32'h1122_3344);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE; bus.req_sign = 1'b0;
      bus.req_addr = 7'h0D; bus.req_wdata = 32'h0000_0055;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);           // now in RMW_DATA
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.resp_valid, bus.resp_err, bus.mem_we, bus.mem_re, bus.resp_rdata, bus.mem_wd,
           bus.mem_addr} !== 73'd0)
         $display("FAIL midreset_outputs got we=%b re=%b addr=%h wd=%h rv=%b exp=all 0",
                  bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wd, bus.resp_valid);
      else passed++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_resp = 0; n_we = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.resp_valid) n_resp++;
         if (bus.mem_we) n_we++;
      end
      total++;
      if (n_resp != 0) $display("FAIL midreset_no_resp got=%0d exp=0", n_resp);
      else passed++;
      total++;
      if (n_we != 0) $display("FAIL midreset_no_write got=%0d exp=0", n_we);
      else passed++;
      total++;
      if (mem[3] !== 32'h1122_3344)
         $display("FAIL midreset_mem got=%h exp=11223344", mem[3]);
      else passed++;
      total++;
      if (bus.req_ready !== 1'b1) $display("FAIL midreset_ready got=%b exp=1", bus.req_ready);
      else passed++;
   endtask

   task automatic test_word();
      int lat, n_re, n_we, n_both, n_resp;
      logic err;
      logic [31:0] rd;
      logic [4:0] wa;
      issue(1'b1, SZ_WORD, 1'b0, 7'h08, 32'hDEAD_BEEF, lat, err, rd, n_re, n_we, n_both,
            n_resp, wa);
      total++;
      if (lat != 2) $display("FAIL wst_latency got=%0d exp=2", lat); else passed++;
      total++;
      if (n_we != 1 || wa !== 5'd2 || n_re != 0)
         $display("FAIL wst_mem got we_cycles=%0d addr=%0d re=%0d exp=1,2,0", n_we, wa, n_re);
      else passed++;
      total++;
      if (mem[2] !== 32'hDEAD_BEEF) $display("FAIL wst_data got=%h exp=deadbeef", mem[2]);
      else passed++;
      total++;
      if (err !== 1'b0 || n_resp != 1)
         $display("FAIL wst_resp got err=%b n=%0d exp=0,1", err, n_resp);
      else passed++;
      issue(1'b0, SZ_WORD, 1'b0, 7'h08, 32'h0, lat, err, rd, n_re, n_we, n_both, n_resp, wa);
      total++;
      if (lat != 3) $display("FAIL wld_latency got=%0d exp=3", lat); else passed++;
      total++;
      if (rd !== 32'hDEAD_BEEF) $display("FAIL wld_data got=%h exp=deadbeef", rd);
      else passed++;
      total++;
      if (n_re != 1 || n_we != 0) $display("FAIL wld_mem got re=%0d we=%0d exp=1,0", n_re, n_we);
      else passed++;
   endtask

   task automatic test_byte();
      int lat, n_re, n_we, n_both, n_resp;
      logic err;
      logic [31:0] rd;
      logic [4:0] wa;
      preload(5'd2, 32'h1122_3344);
      issue(1'b1, SZ_BYTE, 1'b0, 7'h09, 32'h1234_56A5, lat, err, rd, n_re, n_we, n_both,
            n_resp, wa);
      total++;
      if (lat != 4) $display("FAIL bst_latency got=%0d exp=4", lat); else passed++;
      total++;
      if (mem[2] !== 32'h1122_A544) $display("FAIL bst_merge got=%h exp=1122a544", mem[2]);
      else passed++;
      total++;
      if (n_re != 1 || n_we != 1 || n_both != 0)
         $display("FAIL bst_strobes got re=%0d we=%0d both=%0d exp=1,1,0", n_re, n_we, n_both);
      else passed++;
      issue(1'b0, SZ_BYTE, 1'b1, 7'h09, 32'h0, lat, err, rd, n_re, n_we, n_both, n_resp, wa);
      total++;
      if (rd !== 32'hFFFF_FFA5) $display("FAIL bld_signed got=%h exp=ffffffa5", rd);
      else passed++;
      issue(1'b0, SZ_BYTE, 1'b0, 7'h09, 32'h0, lat, err, rd, n_re, n_we, n_both, n_resp, wa);
      total++;
      if (rd !== 32'h0000_00A5) $display("FAIL bld_unsigned got=%h exp=000000a5", rd);
      else passed++;
   endtask

   task automatic test_half();
      int lat, n_re, n_we, n_both, n_resp;
      logic err;
      logic [31:0] rd;
      logic [4:0] wa;
      preload(5'd2, 32'h8000_1234);
      issue(1'b0, SZ_HALF, 1'b1, 7'h0A, 32'h0, lat, err, rd, n_re, n_we, n_both, n_resp, wa);
      total++;
      if (rd !== 32'hFFFF_8000) $display("FAIL hld_signed got=%h exp=ffff8000", rd);
      else passed++;
      issue(1'b0, SZ_HALF, 1'b0, 7'h0A, 32'h0, lat, err, rd, n_re, n_we, n_both, n_resp, wa);
      total++;
      if (rd !== 32'h0000_8000) $display("FAIL hld_unsigned got=%h exp=00008000", rd);
      else passed++;
      issue(1'b1, SZ_HALF, 1'b0, 7'h08, 32'h0000_BEEF, lat, err, rd, n_re, n_we, n_both,
            n_resp, wa);
      total++;
      if (mem[2] !== 32'h8000_BEEF || lat != 4)
         $display("FAIL hst_merge got=%h lat=%0d exp=8000beef lat=4", mem[2], lat);
      else passed++;
   endtask

   task automatic test_misaligned();
      int lat, n_re, n_we, n_both, n_resp;
      logic err;
      logic [31:0] rd;
      logic [4:0] wa;
      logic        v_we   [3];
      logic [1:0]  v_size [3];
      logic [6:0]  v_addr [3];
      v_we[0] = 1'b0; v_size[0] = SZ_WORD; v_addr[0] = 7'h06;
      v_we[1] = 1'b1; v_size[1] = SZ_HALF; v_addr[1] = 7'h05;
      v_we[2] = 1'b0; v_size[2] = 2'b11;   v_addr[2] = 7'h00;
      for (int i = 0; i < 3; i++) begin
         issue(v_we[i], v_size[i], 1'b1, v_addr[i], 32'hFFFF_FFFF, lat, err, rd, n_re, n_we,
               n_both, n_resp, wa);
         total++;
         if (err !== 1'b1 || rd !== 32'h0)
            $display("FAIL misalign%0d_resp got err=%b rdata=%h exp=1,0", i, err, rd);
         else passed++;
         total++;
         if (lat != 1) $display("FAIL misalign%0d_latency got=%0d exp=1", i, lat);
         else passed++;
         total++;
         if (n_re != 0 || n_we != 0)
            $display("FAIL misalign%0d_mem got re=%0d we=%0d exp=0,0", i, n_re, n_we);
         else passed++;
      end
      total++;
      if (mem[2] !== 32'h8000_BEEF) $display("FAIL misalign_mem got=%h exp=8000beef", mem[2]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [11:0] ready_hist;
      logic [11:0] resp_hist;
      logic [31:0] rd0, rd1;
      int          n_acc;
      int          acc1;
      ready_hist = '0; resp_hist = '0; n_acc = 0; acc1 = -1; rd0 = 'x; rd1 = 'x;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_sign = 1'b0;
      bus.req_addr = 7'h08;
      for (int c = 0; c < 12; c++) begin
         if (c == 1) bus.req_addr = 7'h0C;
         if (c == 5) bus.req_valid = 1'b0;
         ready_hist[c] = bus.req_ready;
         if (bus.req_ready && bus.req_valid) begin
            n_acc++;
            if (c != 0) acc1 = c;
         end
         if (bus.resp_valid) begin
            resp_hist[c] = 1'b1;
            if (c == 3) rd0 = bus.resp_rdata;
            if (c == 7) rd1 = bus.resp_rdata;
         end
         @(negedge clk);
      end
      total++;
      if (ready_hist !== 12'b1111_0001_0001)
         $display("FAIL b2b_ready got=%b exp=111100010001", ready_hist);
      else passed++;
      total++;
      if (n_acc != 2 || acc1 != 4)
         $display("FAIL b2b_accept got n=%0d second=%0d exp=2,4", n_acc, acc1);
      else passed++;
      total++;
      if (resp_hist !== 12'b0000_1000_1000)
         $display("FAIL b2b_resp got=%b exp=000010001000", resp_hist);
      else passed++;
      total++;
      if (rd0 !== 32'h8000_BEEF || rd1 !== 32'h1122_3344)
         $display("FAIL b2b_data got=%h,%h exp=8000beef,11223344", rd0, rd1);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_rmw_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
